// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- main control FSM for a multicycle RV32-subset core.
//
// Sequences each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// The opcode is captured in DECODE, and EXEC/MEM/WB decode from that copy, so
// the instruction register may change underneath without affecting control.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset; also forces every output to 0
//   Opcode     instruction[6:0] from the instruction register
//   mem_ready  memory completes the current access this cycle
//   mem_req    memory access request (held until mem_ready is seen)
//   mem_we     1 = store, 0 = read
//   IorD       memory address source: 0 = PC, 1 = ALU result
//   IRWrite    load fetched word into the instruction register
//   PCWrite    load PC+4 into the PC
//   ALUSrc     0 = register operand, 1 = immediate
//   ALUOp      00 = LW/SW/LUI, 01 = branch, 10 = R/I-type
//   MemtoReg   write-back source: 1 = memory data, 0 = ALU
//   RegWrite   register-file write enable
//   Branch     branch-compare cycle
//   illegal    one-cycle pulse for an unsupported opcode
//   retire     one-cycle pulse on the last cycle of each legal instruction
//   state      current state encoding (debug)
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       ALUSrc,
  output logic [1:0] ALUOp,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Branch,
  output logic       illegal,
  output logic       retire,
  output logic [2:0] state
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic [2:0] state_q, state_n;
  logic [6:0] op_q;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_LUI: is_legal = 1'b1;
      default:                                  is_legal = 1'b0;
    endcase
  endfunction

  // {ALUSrc, ALUOp[1:0]} for a captured opcode; reused by EXEC, MEM and WB so
  // the ALU controls stay stable for the whole instruction.
  function automatic logic [2:0] alu_ctl(input logic [6:0] op);
    case (op)
      OP_R:              alu_ctl = 3'b0_10;
      OP_I:              alu_ctl = 3'b1_10;
      OP_BEQ:            alu_ctl = 3'b0_01;
      OP_LW, OP_SW,
      OP_LUI:            alu_ctl = 3'b1_00;
      default:           alu_ctl = 3'b0_00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= 7'b0000000;
    end else begin
      state_q <= state_n;
      if (state_q == DECODE) op_q <= Opcode;
    end
  end

  always_comb begin
    state_n  = FETCH;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 2'b00;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    Branch   = 1'b0;
    illegal  = 1'b0;
    retire   = 1'b0;

    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        // IR and PC updates are gated by the handshake so a stalled fetch
        // never loads a stale word.
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_n = DECODE;
        end else begin
          state_n = FETCH;
        end
      end
      DECODE: begin
        // Legality is judged on the live opcode; it is captured this cycle.
        if (is_legal(Opcode)) begin
          state_n = EXEC;
        end else begin
          illegal = 1'b1;
          state_n = FETCH;
        end
      end
      EXEC: begin
        {ALUSrc, ALUOp} = alu_ctl(op_q);
        case (op_q)
          OP_BEQ: begin
            Branch  = 1'b1;
            retire  = 1'b1;
            state_n = FETCH;
          end
          OP_LW, OP_SW: state_n = MEM;
          default:      state_n = WB;
        endcase
      end
      MEM: begin
        {ALUSrc, ALUOp} = alu_ctl(op_q);
        mem_req = 1'b1;
        IorD    = 1'b1;
        mem_we  = (op_q == OP_SW);
        if (!mem_ready) begin
          state_n = MEM;
        end else if (op_q == OP_SW) begin
          retire  = 1'b1;
          state_n = FETCH;
        end else begin
          state_n = WB;
        end
      end
      WB: begin
        {ALUSrc, ALUOp} = alu_ctl(op_q);
        RegWrite = 1'b1;
        MemtoReg = (op_q == OP_LW);
        retire   = 1'b1;
        state_n  = FETCH;
      end
      default: state_n = FETCH;
    endcase

    // Reset masks everything, including the memory handshake, in the same cycle.
    if (reset) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      ALUSrc   = 1'b0;
      ALUOp    = 2'b00;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      Branch   = 1'b0;
      illegal  = 1'b0;
      retire   = 1'b0;
    end
  end

  assign state = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle pushes the
// hand-computed expected {state, outputs} word; a monitor pops and compares
// on the falling edge.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Opcode;
  logic       mem_ready;
  logic       mem_req, mem_we, IorD, IRWrite, PCWrite, ALUSrc;
  logic [1:0] ALUOp;
  logic       MemtoReg, RegWrite, Branch, illegal, retire;
  logic [2:0] state;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .Branch(Branch), .illegal(illegal), .retire(retire),
    .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Output bit positions: {mem_req, mem_we, IorD, IRWrite, PCWrite, ALUSrc,
  // ALUOp[1:0], MemtoReg, RegWrite, Branch, illegal, retire}
  localparam logic [12:0] NONE  = 13'h0000;
  localparam logic [12:0] MREQ  = 13'h1000;
  localparam logic [12:0] MWE   = 13'h0800;
  localparam logic [12:0] IORD  = 13'h0400;
  localparam logic [12:0] IRW   = 13'h0200;
  localparam logic [12:0] PCW   = 13'h0100;
  localparam logic [12:0] ASRC  = 13'h0080;
  localparam logic [12:0] AOP10 = 13'h0040;
  localparam logic [12:0] AOP01 = 13'h0020;
  localparam logic [12:0] M2R   = 13'h0010;
  localparam logic [12:0] RW    = 13'h0008;
  localparam logic [12:0] BR    = 13'h0004;
  localparam logic [12:0] ILL   = 13'h0002;
  localparam logic [12:0] RET   = 13'h0001;
  localparam logic [12:0] FETCHED = MREQ | IRW | PCW;

  logic [15:0] exp_q[$];
  string       name_q[$];
  int checks   = 0;
  int failures = 0;

  wire [15:0] actual = {state, mem_req, mem_we, IorD, IRWrite, PCWrite,
                        ALUSrc, ALUOp, MemtoReg, RegWrite, Branch, illegal,
                        retire};

  // One clock: drive inputs just after the edge and record what the DUT must
  // show for the rest of this cycle.
  task automatic step(input string nm, input logic rst, input logic [6:0] op,
                      input logic mr, input logic [2:0] st,
                      input logic [12:0] sig);
    @(posedge clk);
    #1;
    reset     = rst;
    Opcode    = op;
    mem_ready = mr;
    exp_q.push_back({st, sig});
    name_q.push_back(nm);
  endtask

  // Monitor: compare every recorded cycle away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (actual !== e) begin
        failures++;
        $display("FAIL %s: got state=%0d sig=%013b, want state=%0d sig=%013b",
                 n, actual[15:13], actual[12:0], e[15:13], e[12:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; Opcode = 7'd0; mem_ready = 1'b0;

    step("rst0", 1, 7'd0, 1, 3'd0, NONE);
    step("rst1", 1, OP_R, 1, 3'd0, NONE);

    // R-type, no waits: 0,1,2,4
    step("r_fetch",  0, OP_R, 1, 3'd0, FETCHED);
    step("r_decode", 0, OP_R, 1, 3'd1, NONE);
    step("r_exec",   0, OP_R, 1, 3'd2, AOP10);
    step("r_wb",     0, OP_R, 1, 3'd4, AOP10 | RW | RET);

    // LW with two MEM wait cycles: 0,1,2,3,3,3,4
    step("lw_fetch",  0, OP_LW, 1, 3'd0, FETCHED);
    step("lw_decode", 0, OP_LW, 0, 3'd1, NONE);
    step("lw_exec",   0, OP_LW, 0, 3'd2, ASRC);
    step("lw_mem_w0", 0, OP_LW, 0, 3'd3, MREQ | IORD | ASRC);
    step("lw_mem_w1", 0, OP_LW, 0, 3'd3, MREQ | IORD | ASRC);
    step("lw_mem_rd", 0, OP_LW, 1, 3'd3, MREQ | IORD | ASRC);
    step("lw_wb",     0, OP_LW, 0, 3'd4, ASRC | M2R | RW | RET);

    // SW, no waits: 0,1,2,3
    step("sw_fetch",  0, OP_SW, 1, 3'd0, FETCHED);
    step("sw_decode", 0, OP_SW, 1, 3'd1, NONE);
    step("sw_exec",   0, OP_SW, 1, 3'd2, ASRC);
    step("sw_mem",    0, OP_SW, 1, 3'd3, MREQ | MWE | IORD | ASRC | RET);

    // BEQ with one fetch wait: 0,0,1,2
    step("beq_fetch_w", 0, OP_BEQ, 0, 3'd0, MREQ);
    step("beq_fetch",   0, OP_BEQ, 1, 3'd0, FETCHED);
    step("beq_decode",  0, OP_BEQ, 0, 3'd1, NONE);
    step("beq_exec",    0, OP_BEQ, 0, 3'd2, AOP01 | BR | RET);

    // Illegal opcode: pulse in DECODE, straight back to FETCH
    step("ill_fetch",  0, OP_BAD, 1, 3'd0, FETCHED);
    step("ill_decode", 0, OP_BAD, 1, 3'd1, ILL);

    // I-type with Opcode changed under EXEC/WB
    step("i_fetch",  0, OP_I, 1, 3'd0, FETCHED);
    step("i_decode", 0, OP_I, 1, 3'd1, NONE);
    step("i_exec",   0, 7'd0, 1, 3'd2, ASRC | AOP10);
    step("i_wb",     0, 7'd0, 1, 3'd4, ASRC | AOP10 | RW | RET);

    // LUI
    step("lui_fetch",  0, OP_LUI, 1, 3'd0, FETCHED);
    step("lui_decode", 0, OP_LUI, 1, 3'd1, NONE);
    step("lui_exec",   0, OP_LUI, 1, 3'd2, ASRC);
    step("lui_wb",     0, OP_LUI, 1, 3'd4, ASRC | RW | RET);

    // Reset during a stalled LW MEM access aborts without retire
    step("ab_fetch",  0, OP_LW, 1, 3'd0, FETCHED);
    step("ab_decode", 0, OP_LW, 1, 3'd1, NONE);
    step("ab_exec",   0, OP_LW, 0, 3'd2, ASRC);
    step("ab_mem",    0, OP_LW, 0, 3'd3, MREQ | IORD | ASRC);
    step("ab_rst",    1, OP_LW, 0, 3'd0, NONE);
    step("ab_after",  0, OP_LW, 0, 3'd0, MREQ);
    step("ab_fetch2", 0, OP_LW, 1, 3'd0, FETCHED);
    step("ab_decode2",0, OP_LW, 1, 3'd1, NONE);

    // Drain the scoreboard with a bounded wait
    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        failures++;
        $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Opcode  input  7  instruction[6:0] from the instruction register.
REQ-005 mem_ready  input  1  memory completes the current access this cycle.
REQ-006 mem_req  output  1  memory access request.
REQ-007 mem_we  output  1  1 = write access (store), 0 = read.
REQ-008 IorD  output  1  memory address source: 0 = PC, 1 = ALU result.
REQ-009 IRWrite  output  1  load fetched word into the instruction register.
REQ-010 PCWrite  output  1  load PC+4 into the PC.
REQ-011 ALUSrc  output  1  0 = register operand, 1 = immediate.
REQ-012 ALUOp  output  2  00 = LW/SW/LUI, 01 = branch, 10 = R/I-type.
REQ-013 MemtoReg  output  1  write-back source: 1 = memory data, 0 = ALU.
REQ-014 RegWrite  output  1  register-file write enable.
REQ-015 Branch  output  1  branch-compare cycle; PC update on a taken branch is done by the datapath.
REQ-016 illegal  output  1  one-cycle pulse for an unsupported opcode.
REQ-017 retire  output  1  one-cycle pulse on the last cycle of each legal instruction.
REQ-018 state  output  3  current state encoding, for debug and verification.

Function
REQ-019 The supported opcodes SHALL be:
- R 0110011
- I 0010011
- LW 0000011
- SW 0100011
- BEQ 1100011
- LUI 0110111
REQ-020 The states and encodings SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5-7 go to FETCH on the next cycle with all outputs 0.
REQ-021 FETCH SHALL behave as follows:
- mem_req=1, IorD=0, mem_we=0.
- Hold while mem_ready=0.
- When mem_ready=1: IRWrite=1 and PCWrite=1 in the same cycle (Mealy, gated by mem_ready), then go to DECODE.
REQ-022 DECODE SHALL be one cycle and SHALL latch Opcode into an internal register.
- Legal opcode: go to EXEC.
- Otherwise: illegal=1 for this cycle, then go to FETCH.
REQ-023 EXEC SHALL drive its outputs from the latched opcode, ignoring the live Opcode:
- R: ALUSrc=0, ALUOp=10, go to WB.
- I: ALUSrc=1, ALUOp=10, go to WB.
- LUI: ALUSrc=1, ALUOp=00, go to WB.
- LW/SW: ALUSrc=1, ALUOp=00, go to MEM.
- BEQ: ALUSrc=0, ALUOp=01, Branch=1, retire=1, go to FETCH.
REQ-024 MEM SHALL behave as follows:
- mem_req=1, IorD=1, mem_we=1 only for SW.
- Hold while mem_ready=0.
- When mem_ready=1: LW goes to WB; SW pulses retire=1 and goes to FETCH.
REQ-025 WB SHALL drive RegWrite=1, MemtoReg=1 only for LW, and retire=1, then go to FETCH.
REQ-026 Every output not listed for a state SHALL be 0 in that state.
REQ-027 ALUSrc and ALUOp SHALL be held in MEM and WB at their EXEC values.
REQ-028 mem_ready SHALL be ignored in DECODE, EXEC and WB.
REQ-029 With zero memory wait states, latency from entering FETCH to retire SHALL be:
- BEQ: 3 cycles.
- R, I, LUI, SW: 4 cycles.
- LW: 5 cycles.
- Each wait cycle in FETCH or MEM adds 1 cycle.
REQ-030 At most one mem_req transaction SHALL be outstanding; mem_req SHALL stay high until the cycle in which mem_ready=1 is sampled.

Reset
REQ-031 While reset=1 at a clock edge, the next state SHALL be FETCH and the latched opcode SHALL be 0000000.
REQ-032 During any cycle with reset=1, all outputs SHALL be forced to 0 combinationally, including mem_req, IRWrite and PCWrite.
REQ-033 Reset mid-operation (any state, including a stalled MEM) SHALL abort the instruction without retire; the first cycle after reset deasserts is FETCH with mem_req=1.

Verification
REQ-034 R-type (0110011), mem_ready always 1 -> state sequence 0,1,2,4,0:
- IRWrite=PCWrite=1 in cycle 1.
- ALUOp=10, ALUSrc=0 in EXEC.
- RegWrite=1, retire=1 in WB.
REQ-035 LW (0000011), mem_ready held 0 for 2 cycles in MEM -> state sequence 0,1,2,3,3,3,4,0:
- mem_req=1, IorD=1, mem_we=0 throughout MEM.
- MemtoReg=1, RegWrite=1 in WB.
REQ-036 SW (0100011) then BEQ (1100011), zero wait -> SW: 0,1,2,3,0 with mem_we=1 in MEM; BEQ: 0,1,2,0 with Branch=1, ALUOp=01, retire=1 in EXEC.
REQ-037 Illegal opcode 1111111 -> illegal=1 in DECODE, next state FETCH, no RegWrite, no retire.
REQ-038 Opcode changed to 0000000 during EXEC of an I-type instruction -> outputs stay ALUSrc=1, ALUOp=10, and WB is still reached.
REQ-039 reset=1 asserted in MEM with mem_ready=0 -> all outputs 0 in that cycle, state=0 after the edge, no retire pulse.
